// File: rtl/ps2_scan_sequencer.sv
// Turns raw PS/2 bytes into {ext,brk,code} key events and queues them in a show-ahead FIFO.
// Handles E0/F0/E1 prefixes, drops status bytes, and can optionally drop typematic repeats.
module ps2_scan_sequencer #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 200000,
  parameter int FILTER_REP  = 1
) (
  input  logic                     inclock,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [9:0]               evt_data,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic [7:0]               last_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_SKIP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      skip_cnt_q, skip_cnt_d;
  logic [TW-1:0]   tmo_q;
  logic [7:0]      held_code_q;
  logic            held_ext_q;
  logic [7:0]      last_code_q;
  logic            overflow_q;
  logic [9:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;

  logic            ev_ok, ev_ext, ev_brk, is_rep, push, pop, full, do_push, timed_out;
  logic [7:0]      ev_code;

  assign timed_out = (state_q != S_IDLE) && !rx_valid && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    ev_ok      = 1'b0;
    ev_ext     = 1'b0;
    ev_brk     = 1'b0;
    ev_code    = rx_data;
    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          case (rx_data)
            8'hE0: state_d = S_E0;
            8'hF0: state_d = S_F0;
            8'hE1: begin
              state_d    = S_SKIP;
              skip_cnt_d = 3'd7;
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: state_d = S_IDLE;
            default: ev_ok = 1'b1;
          endcase
        end
        S_E0: begin
          if (rx_data == 8'hF0) begin
            state_d = S_E0F0;
          end else begin
            state_d = S_IDLE;
            // 12 after E0 is a fake-shift byte emitted around extended keys
            ev_ok   = (rx_data != 8'h12);
            ev_ext  = 1'b1;
          end
        end
        S_F0: begin
          state_d = S_IDLE;
          ev_ok   = 1'b1;
          ev_brk  = 1'b1;
        end
        S_E0F0: begin
          state_d = S_IDLE;
          ev_ok   = (rx_data != 8'h12);
          ev_ext  = 1'b1;
          ev_brk  = 1'b1;
        end
        S_SKIP: begin
          skip_cnt_d = skip_cnt_q - 3'd1;
          if (skip_cnt_q == 3'd1) begin
            state_d = S_IDLE;
            ev_ok   = 1'b1;
            ev_ext  = 1'b1;
            ev_code = 8'h77;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timed_out) begin
      state_d = S_IDLE;
    end
  end

  assign is_rep  = (FILTER_REP != 0) && !ev_brk && (ev_ext == held_ext_q) && (ev_code == held_code_q);
  assign push    = ev_ok && !is_rep;
  assign pop     = evt_valid && evt_ready;
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_push = push && (!full || pop);

  always_ff @(posedge inclock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      skip_cnt_q  <= 3'd0;
      tmo_q       <= '0;
      held_code_q <= 8'h00;
      held_ext_q  <= 1'b0;
      last_code_q <= 8'h00;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      if (rx_valid || state_q == S_IDLE || timed_out) tmo_q <= '0;
      else                                             tmo_q <= tmo_q + TW'(1);

      // held_* tracks the filter decision, independent of whether the FIFO had room
      if (push && !ev_brk) begin
        held_ext_q  <= ev_ext;
        held_code_q <= ev_code;
        last_code_q <= ev_code;
      end else if (push && ev_brk && ev_ext == held_ext_q && ev_code == held_code_q) begin
        held_code_q <= 8'h00;
      end

      if (do_push) begin
        mem_q[wr_ptr_q] <= {ev_ext, ev_brk, ev_code};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase

      if (push && full && !pop) overflow_q <= 1'b1;
      else if (clr_overflow)    overflow_q <= 1'b0;
    end
  end

  assign evt_data   = mem_q[rd_ptr_q];
  assign evt_valid  = (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign last_code  = last_code_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Scoreboard bench for ps2_scan_sequencer: expected events are queued as bytes are sent
// and compared as the consumer pops them; a second instance runs with repeat filtering off.
module tb_ps2_scan_sequencer;

  localparam int DEPTH = 8;
  localparam int TMO   = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       evt_ready;
  logic       clr_overflow;
  logic       en1;

  logic [9:0] evt_data;
  logic       evt_valid;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [7:0] last_code;

  logic [9:0] evt_data1;
  logic       evt_valid1;
  logic [3:0] fifo_count1;
  logic       overflow1;
  logic [7:0] last_code1;

  int n_total = 0;
  int n_bad   = 0;
  logic [9:0] exp_q  [$];
  logic [9:0] exp1_q [$];

  always #5 clk = ~clk;

  ps2_scan_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .FILTER_REP(1)) dut (
    .inclock(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .fifo_count(fifo_count), .overflow(overflow), .clr_overflow(clr_overflow),
    .last_code(last_code));

  ps2_scan_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .FILTER_REP(0)) dut_nf (
    .inclock(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid & en1),
    .evt_data(evt_data1), .evt_valid(evt_valid1), .evt_ready(1'b1),
    .fifo_count(fifo_count1), .overflow(overflow1), .clr_overflow(1'b0),
    .last_code(last_code1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) chk("unexpected_evt", {22'd0, evt_data}, 32'h3FF);
      else                   chk("evt", {22'd0, evt_data}, {22'd0, exp_q.pop_front()});
    end
    if (!reset && evt_valid1) begin
      if (exp1_q.size() == 0) chk("unexpected_evt_nf", {22'd0, evt_data1}, 32'h3FF);
      else                    chk("evt_nf", {22'd0, evt_data1}, {22'd0, exp1_q.pop_front()});
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    evt_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && exp1_q.size() == 0 && !evt_valid && !evt_valid1) break;
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_valid"}, {31'd0, evt_valid}, 0);
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; evt_ready = 1'b0;
    clr_overflow = 1'b0; en1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset state and first make
    chk("rst_valid", {31'd0, evt_valid}, 0);
    chk("rst_count", {28'd0, fifo_count}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk("rst_last", {24'd0, last_code}, 0);
    exp_q.push_back(10'h01C);
    send(8'h1C);
    chk("t1_valid", {31'd0, evt_valid}, 1);
    chk("t1_data", {22'd0, evt_data}, 32'h01C);
    chk("t1_last", {24'd0, last_code}, 32'h1C);
    chk("t1_count", {28'd0, fifo_count}, 1);
    drain("t1");

    // 2: extended break, then a plain make proves FSM returned to IDLE
    do_reset();
    evt_ready = 1'b1;
    send(8'hE0); send(8'hF0);
    exp_q.push_back(10'h375);
    send(8'h75);
    exp_q.push_back(10'h01C);
    send(8'h1C);
    drain("t2");

    // 3: typematic repeats, filtered and unfiltered
    do_reset();
    en1 = 1'b1;
    exp_q.push_back(10'h01C); exp_q.push_back(10'h11C);
    exp1_q.push_back(10'h01C); exp1_q.push_back(10'h01C);
    exp1_q.push_back(10'h01C); exp1_q.push_back(10'h11C);
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain("t3");
    chk("t3_nf_left", exp1_q.size(), 0);
    chk("t3_last", {24'd0, last_code}, 32'h1C);
    en1 = 1'b0;

    // 4: fill, overflow, clear, push+pop while full
    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < DEPTH) exp_q.push_back({2'b00, 8'(8'h10 + i)});
      send(8'(8'h10 + i));
    end
    chk("t4_count", {28'd0, fifo_count}, DEPTH);
    chk("t4_ovf", {31'd0, overflow}, 1);
    chk("t4_head", {22'd0, evt_data}, 32'h010);
    chk("t4_last", {24'd0, last_code}, 32'h18);
    @(posedge clk); #1 clr_overflow = 1'b1;
    @(posedge clk); #1 clr_overflow = 1'b0;
    chk("t4_ovf_clr", {31'd0, overflow}, 0);
    exp_q.push_back(10'h019);
    @(posedge clk); #1;
    rx_data = 8'h19; rx_valid = 1'b1; evt_ready = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; evt_ready = 1'b0;
    chk("t4_count_pp", {28'd0, fifo_count}, DEPTH);
    chk("t4_ovf_pp", {31'd0, overflow}, 0);
    chk("t4_head_pp", {22'd0, evt_data}, 32'h011);
    drain("t4");

    // 5: Pause sequence, then prefix timeout
    do_reset();
    evt_ready = 1'b1;
    exp_q.push_back(10'h277);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    drain("t5a");
    send(8'hE0);
    repeat (TMO + 10) @(posedge clk);
    exp_q.push_back(10'h01C);
    send(8'h1C);
    drain("t5b");

    // 6: reset discards a pending break prefix; status bytes dropped
    do_reset();
    send(8'hF0);
    do_reset();
    exp_q.push_back(10'h01C);
    send(8'h1C);
    send(8'hAA); send(8'hFA);
    drain("t6");
    chk("t6_count", {28'd0, fifo_count}, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
